// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor and its program sequencer:
// opcode and sequencer-state encodings, instruction field positions and
// small decode helpers.
package simple_proc_pkg;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        LOAD = 3'd2,
        GO   = 3'd3,
        EXEC = 3'd4,
        HALT = 3'd5,
        ERR  = 3'd6
    } seq_state_t;

    // Instruction word layout: IR[8:6] opcode, IR[5:3] RX, IR[2:0] RY.
    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 3;
    localparam int RY_HI  = 2;
    localparam int RY_LO  = 0;

    // Only the four opcodes with a clear top bit exist.
    function automatic logic opc_is_legal(input logic [2:0] opc);
        return (opc[2] == 1'b0);
    endfunction

    // mvi is the only instruction followed by an immediate word.
    function automatic logic opc_is_mvi(input logic [2:0] opc);
        return (opc == OP_MVI);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// ROM read port plus processor Din/run/Done handshake between the
// program sequencer (master) and the ROM/processor side (slave).
interface program_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] din;
    logic              run;
    logic              done;

    modport master (
        output mem_addr,
        output din,
        output run,
        input  mem_data,
        input  done
    );

    modport slave (
        input  mem_addr,
        input  din,
        input  run,
        output mem_data,
        output done
    );
endinterface

// File: rtl/seq_watchdog.sv
// Cycle counter bounding how long the sequencer waits for Done.
// Cleared outside EXEC, counts each EXEC cycle from 0, and flags expiry
// when the count reaches TIMEOUT. It saturates so it can never wrap back
// into a "not expired" value.
module seq_watchdog #(
    parameter int  TIMEOUT = 15,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CW-1:0] cnt_r;

    // Count enabled cycles, holding at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != CW'(TIMEOUT))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == CW'(TIMEOUT));
endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions (and mvi immediates) from a
// synchronous ROM, presents them on the processor Din bus, pulses run,
// waits for Done and advances the PC. Stops on halt request, end of
// program, illegal opcode or watchdog timeout.
import simple_proc_pkg::*;

module program_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 9,
    parameter int LAST_ADDR = 31,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      halt_req,
    program_sequencer_if.master       bus,
    output logic [ADDR_W-1:0]         pc,
    output logic [15:0]               instr_cnt,
    output logic                      busy,
    output logic                      halted,
    output logic                      err
);
    // PC arithmetic is one bit wider so running past LAST_ADDR is seen
    // as end of program instead of wrapping to 0.
    localparam int PW = ADDR_W + 1;

    seq_state_t        state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] din_r, din_s;
    logic [DATA_W-1:0] instr_q_r, instr_q_s;
    logic [DATA_W-1:0] imm_q_r, imm_q_s;
    logic [15:0]       cnt_r, cnt_s;
    logic              run_r, run_s;
    logic              busy_r, busy_s;
    logic              halted_r, halted_s;
    logic              err_r, err_s;

    logic [2:0]        ld_opc_s;
    logic              q_is_mvi_s;
    logic [PW-1:0]     pc_plus1_s;
    logic [PW-1:0]     pc_sum_s;
    logic              wdog_expired_s;

    assign ld_opc_s   = bus.mem_data[OPC_HI:OPC_LO];
    assign q_is_mvi_s = opc_is_mvi(instr_q_r[OPC_HI:OPC_LO]);
    assign pc_plus1_s = {1'b0, pc_r} + PW'(1);
    assign pc_sum_s   = {1'b0, pc_r} + (q_is_mvi_s ? PW'(2) : PW'(1));

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r != EXEC),
        .enable  (state_r == EXEC),
        .expired (wdog_expired_s)
    );

    // Next-state and next-output logic; all outputs are registered from here.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        mem_addr_s = mem_addr_r;
        din_s     = din_r;
        instr_q_s = instr_q_r;
        imm_q_s   = imm_q_r;
        cnt_s     = cnt_r;
        case (state_r)
            IDLE, HALT: begin
                if (start) begin
                    pc_s       = '0;
                    cnt_s      = 16'd0;
                    mem_addr_s = '0;
                    state_s    = RD_I;
                end else begin
                    state_s = state_r;
                end
            end
            RD_I: begin
                // Prefetch the word after the instruction: the mvi immediate.
                mem_addr_s = pc_plus1_s[ADDR_W-1:0];
                state_s    = LOAD;
            end
            LOAD: begin
                instr_q_s = bus.mem_data;
                if (!opc_is_legal(ld_opc_s)) begin
                    state_s = ERR;
                end else if (opc_is_mvi(ld_opc_s) && (pc_r == ADDR_W'(LAST_ADDR))) begin
                    state_s = ERR;
                end else begin
                    din_s   = bus.mem_data;
                    state_s = GO;
                end
            end
            GO: begin
                imm_q_s = bus.mem_data;
                din_s   = q_is_mvi_s ? bus.mem_data : instr_q_r;
                state_s = EXEC;
            end
            EXEC: begin
                if (bus.done) begin
                    // Past the top of the address space pc sticks at all-ones.
                    pc_s  = pc_sum_s[ADDR_W] ? '1 : pc_sum_s[ADDR_W-1:0];
                    cnt_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
                    if (halt_req || (pc_sum_s > PW'(LAST_ADDR))) begin
                        state_s = HALT;
                    end else begin
                        mem_addr_s = pc_sum_s[ADDR_W-1:0];
                        state_s    = RD_I;
                    end
                end else if (wdog_expired_s) begin
                    state_s = ERR;
                end else begin
                    state_s = EXEC;
                end
            end
            ERR: begin
                state_s = ERR;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        run_s    = (state_s == GO);
        busy_s   = (state_s == RD_I) || (state_s == LOAD) ||
                   (state_s == GO)   || (state_s == EXEC);
        halted_s = (state_s == HALT);
        err_s    = (state_s == ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= '0;
            mem_addr_r <= '0;
            din_r      <= '0;
            instr_q_r  <= '0;
            imm_q_r    <= '0;
            cnt_r      <= 16'd0;
            run_r      <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            mem_addr_r <= mem_addr_s;
            din_r      <= din_s;
            instr_q_r  <= instr_q_s;
            imm_q_r    <= imm_q_s;
            cnt_r      <= cnt_s;
            run_r      <= run_s;
            busy_r     <= busy_s;
            halted_r   <= halted_s;
            err_r      <= err_s;
        end
    end

    // In LOAD the ROM word goes straight to Din so the processor IR can load it.
    assign bus.din      = (state_r == LOAD) ? bus.mem_data : din_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.run      = run_r;
    assign pc           = pc_r;
    assign instr_cnt    = cnt_r;
    assign busy         = busy_r;
    assign halted       = halted_r;
    assign err          = err_r;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: behavioural ROM and processor,
// scoreboard of expected Din values at each run pulse and during EXEC.
module tb_program_sequencer;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 9;
    localparam int LAST_ADDR = 2;
    localparam int TIMEOUT   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              halt_req;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_cnt;
    logic              busy;
    logic              halted;
    logic              err;

    program_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    program_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST_ADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt_req  (halt_req),
        .bus       (bus),
        .pc        (pc),
        .instr_cnt (instr_cnt),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Synchronous ROM: data one cycle after address.
    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

    // Processor model: Done after lat EXEC cycles (mv/mvi 1, add/sub 3).
    // ovr > 0 forces that latency, ovr < 0 withholds Done.
    int ovr = 0;
    int dcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            dcnt     <= 0;
            bus.done <= 1'b0;
        end else if (bus.run) begin
            bus.done <= 1'b0;
            if (ovr < 0)      dcnt <= 0;
            else if (ovr > 0) dcnt <= ovr;
            else              dcnt <= (bus.din[8:7] == 2'b01) ? 3 : 1;
        end else if (!busy) begin
            dcnt     <= 0;
            bus.done <= 1'b0;
        end else if (dcnt == 1) begin
            dcnt     <= 0;
            bus.done <= 1'b1;
        end else if (dcnt > 1) begin
            dcnt     <= dcnt - 1;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
        end
    end

    // Scoreboard: Din expected at the run pulse and throughout EXEC.
    logic [DATA_W-1:0] run_q  [$];
    logic [DATA_W-1:0] exec_q [$];
    logic [DATA_W-1:0] exec_exp;
    logic              in_exec = 1'b0;
    int                run_cnt = 0;

    task automatic push_instr(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] imm);
        run_q.push_back(w);
        exec_q.push_back((w[8:6] == 3'b001) ? imm : w);
    endtask

    always @(negedge clk) begin
        if (bus.run) begin
            run_cnt <= run_cnt + 1;
            if (run_q.size() == 0) begin
                check_eq("sb_underflow", run_q.size(), 1);
            end else begin
                check_eq("run_din", bus.din, run_q.pop_front());
                exec_exp <= exec_q.pop_front();
                in_exec  <= 1'b1;
            end
        end else if (in_exec) begin
            if (!busy) begin
                in_exec <= 1'b0;
            end else begin
                check_eq("exec_din", bus.din, exec_exp);
                if (bus.done) in_exec <= 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Count cycles until HALT or ERR, bounded.
    task automatic wait_end(input int max, output int n);
        n = 0;
        while (!(halted || err) && (n < max)) begin
            @(negedge clk);
            n++;
        end
        if (!(halted || err)) check_eq("wait_end_timeout", {31'b0, halted | err}, 1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int rc;
        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 9'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_din", bus.din, 0);
        check_eq("rst_cnt", instr_cnt, 0);
        check_eq("rst_flags", {run_cnt[3:0], bus.run, busy, halted, err}, 0);

        // 1: mvi R0,5 ; mv R1,R0
        rom[0] = 9'b001_000_000; rom[1] = 9'h005; rom[2] = 9'b000_001_000;
        push_instr(9'b001_000_000, 9'h005);
        push_instr(9'b000_001_000, 9'h000);
        pulse_start();
        wait_end(100, n);
        check_eq("t1_cycles", n, 8);
        check_eq("t1_halted", {busy, halted, err}, 3'b010);
        check_eq("t1_pc", pc, 3);
        check_eq("t1_cnt", instr_cnt, 2);
        check_eq("t1_runs", run_cnt, 2);

        // 2: add R0,R1 then two mv, restart from HALT
        rom[0] = 9'b010_000_001; rom[1] = 9'b000_010_000; rom[2] = 9'b000_011_000;
        push_instr(9'b010_000_001, 9'h000);
        push_instr(9'b000_010_000, 9'h000);
        push_instr(9'b000_011_000, 9'h000);
        pulse_start();
        check_eq("t2_restart_cnt", instr_cnt, 0);
        check_eq("t2_restart_pc", pc, 0);
        n = 0;
        while ((instr_cnt != 16'd1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check_eq("t2_add_cycles", n, 6);
        check_eq("t2_pc1", pc, 1);
        wait_end(100, n);
        check_eq("t2_pc", pc, 3);
        check_eq("t2_cnt", instr_cnt, 3);

        // 3: illegal opcode -> ERR in LOAD, no run, start ignored
        rom[0] = 9'b100_000_000;
        rc = run_cnt;
        pulse_start();
        wait_end(50, n);
        check_eq("t3_cycles", n, 2);
        check_eq("t3_err", {busy, halted, err}, 3'b001);
        check_eq("t3_pc", pc, 0);
        check_eq("t3_noruns", run_cnt, rc);
        pulse_start();
        repeat (3) @(negedge clk);
        check_eq("t3_sticky", {busy, halted, err}, 3'b001);
        check_eq("t3_noruns2", run_cnt, rc);
        do_reset();
        check_eq("t3_rst_clear", {busy, halted, err}, 3'b000);

        // 4a: Done withheld -> watchdog error TIMEOUT+1 cycles into EXEC
        rom[0] = 9'b000_001_010; rom[1] = 9'b000_010_011; rom[2] = 9'b000_011_100;
        ovr = -1;
        push_instr(9'b000_001_010, 9'h000);
        pulse_start();
        wait_end(100, n);
        check_eq("t4_wdog_cycles", n, 3 + TIMEOUT + 1);
        check_eq("t4_err", err, 1);
        check_eq("t4_pc", pc, 0);
        do_reset();

        // 4b: Done on the expiry cycle wins
        ovr = TIMEOUT + 1;
        push_instr(9'b000_001_010, 9'h000);
        push_instr(9'b000_010_011, 9'h000);
        push_instr(9'b000_011_100, 9'h000);
        pulse_start();
        wait_end(200, n);
        check_eq("t4_edge_state", {busy, halted, err}, 3'b010);
        check_eq("t4_edge_cnt", instr_cnt, 3);
        ovr = 0;
        do_reset();

        // 5: halt_req ignored in IDLE, then stops after first instruction
        halt_req = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_idle_halt", {busy, halted, err}, 3'b000);
        push_instr(9'b000_001_010, 9'h000);
        pulse_start();
        wait_end(50, n);
        check_eq("t5_halted", halted, 1);
        check_eq("t5_pc", pc, 1);
        check_eq("t5_cnt", instr_cnt, 1);
        halt_req = 1'b0;
        push_instr(9'b000_001_010, 9'h000);
        push_instr(9'b000_010_011, 9'h000);
        push_instr(9'b000_011_100, 9'h000);
        pulse_start();
        check_eq("t5_restart_pc", pc, 0);
        check_eq("t5_restart_cnt", instr_cnt, 0);
        wait_end(100, n);
        check_eq("t5_pc_end", pc, 3);
        check_eq("t5_cnt_end", instr_cnt, 3);

        // 6a: rst in the GO cycle
        push_instr(9'b000_001_010, 9'h000);
        pulse_start();
        n = 0;
        while (!bus.run && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_saw_run", bus.run, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_run", bus.run, 0);
        check_eq("t6_rst_flags", {busy, halted, err}, 3'b000);
        check_eq("t6_rst_regs", {pc, bus.mem_addr, bus.din, instr_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 6b: mvi at LAST_ADDR -> ERR in LOAD
        rom[2] = 9'b001_000_000;
        push_instr(9'b000_001_010, 9'h000);
        push_instr(9'b000_010_011, 9'h000);
        rc = run_cnt;
        pulse_start();
        wait_end(100, n);
        check_eq("t6_mvi_err", err, 1);
        check_eq("t6_mvi_pc", pc, 2);
        check_eq("t6_mvi_cnt", instr_cnt, 2);
        check_eq("t6_mvi_runs", run_cnt - rc, 2);

        @(negedge clk);
        check_eq("sb_empty", run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
